iob_sync_fifo_asym: RTL and testbench

Single-clock FIFO with independent write and read data widths whose ratio is a power of two. It is the parametrised successor of the existing symmetric sync FIFO. It adds width conversion, a full-range occupancy count in narrow-word units, and programmable almost-full/almost-empty flags. It sits between stream producers and consumers of differing widths, e.g. 8-bit byte streams feeding 32-bit datapath units and the reverse.

---
 rtl/iob_sync_fifo_asym.sv | 218 +++++++++++++++++++++
 tb/tb_iob_sync_fifo_asym.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_sync_fifo_asym.sv
// ---------------------------------------------------------------------------
// iob_sync_fifo_asym
//
// Single-clock FIFO with independent write and read widths. The ratio
// max(W,R)/min(W,R) must be a power of two. Storage is split into
// max(WR,RR) banks. Each bank is MINW bits wide, where MINW = min(W,R). All
// pointers and the occupancy count are in MINW units. Packing is
// little-endian: the narrow word at the lowest pointer lands in bits
// [MINW-1:0] of the wide word.
//
// Optional build macro:
//   IOB_SYNC_FIFO_ASYM_FWFT_EN - first-word-fall-through. A prefetch register
//   holds the head word, so r_data shows the head whenever empty=0 and
//   read_en pops it. level includes the prefetched word. When the macro is
//   undefined, r_data updates on the edge that accepts a read.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst           asynchronous active-high reset
//   w_data        write data (W_DATA_W)
//   write_en      write request, ignored while full
//   full          a write cannot be accepted
//   almost_full   level >= AFULL_LVL
//   r_data        read data (R_DATA_W)
//   read_en       read request, ignored while empty
//   empty         a read cannot be accepted
//   almost_empty  level <= AEMPTY_LVL
//   level         occupancy in MINW words, 0..DEPTH inclusive (ADDR_W+1)
// ---------------------------------------------------------------------------

// Simple dual-port memory with synchronous write and combinational read.
// The registered read stage lives in the FIFO itself.
module iob_2p_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];
endmodule

module iob_sync_fifo_asym #(
    parameter int W_DATA_W   = 32,
    parameter int R_DATA_W   = 8,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = (2**ADDR_W) - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W_DATA_W-1:0] w_data,
    input  logic                write_en,
    output logic                full,
    output logic                almost_full,
    output logic [R_DATA_W-1:0] r_data,
    input  logic                read_en,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDR_W:0]     level
);
    localparam int MINW   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int MAXW   = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int WR     = W_DATA_W / MINW;
    localparam int RR     = R_DATA_W / MINW;
    localparam int NB     = MAXW / MINW;
    localparam int BANK_W = $clog2(NB);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int DEPTH  = 2**ADDR_W;

    // Two bits wider than the pointers, so level + WR cannot overflow
    // before the compare.
    localparam int CW = ADDR_W + 2;

    localparam logic [CW-1:0]     WR_L     = CW'(WR);
    localparam logic [CW-1:0]     RR_L     = CW'(RR);
    localparam logic [CW-1:0]     FULL_THR = CW'(DEPTH - WR);
    localparam logic [CW-1:0]     AF_THR   = CW'(AFULL_LVL);
    localparam logic [CW-1:0]     AE_THR   = CW'(AEMPTY_LVL);
    localparam logic [ADDR_W-1:0] WR_P     = ADDR_W'(WR);
    localparam logic [ADDR_W-1:0] RR_P     = ADDR_W'(RR);

    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rptr;
    logic                we_i;
    logic                pop;
    logic                mem_rd;
    logic [CW-1:0]       lvl_cur;
    logic [CW-1:0]       lvl_next;
    logic [ROW_W-1:0]    w_row;
    logic [ROW_W-1:0]    r_row;
    logic [MINW-1:0]     bank_rdata [NB];
    logic [R_DATA_W-1:0] rd_word;

    assign we_i = write_en & ~full;
    assign pop  = read_en & ~empty;

    assign lvl_cur  = CW'(level);
    assign lvl_next = lvl_cur + (we_i ? WR_L : '0) - (pop ? RR_L : '0);

    // Steps are aligned, so the bank row is the pointer with its bank bits
    // dropped. A wide access covers a whole row.
    assign w_row = wptr[ADDR_W-1:BANK_W];
    assign r_row = rptr[ADDR_W-1:BANK_W];

`ifdef IOB_SYNC_FIFO_ASYM_FWFT_EN
    logic          pf_valid;
    logic [CW-1:0] mem_lvl;

    // Refill the prefetch stage whenever it is free or being popped and
    // memory holds a complete read word.
    assign mem_lvl = lvl_cur - (pf_valid ? RR_L : '0);
    assign mem_rd  = (mem_lvl >= RR_L) & (~pf_valid | pop);
`else
    assign mem_rd = pop;
`endif

    // ---------------------------------------------------------------------
    // Storage banks
    // ---------------------------------------------------------------------
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic            bank_we;
        logic [MINW-1:0] bank_wdata;

        if (NB == 1) begin : g_one
            assign bank_we    = we_i;
            assign bank_wdata = w_data;
        end else if (WR > 1) begin : g_wide_wr
            assign bank_we    = we_i;
            assign bank_wdata = w_data[b*MINW +: MINW];
        end else begin : g_narrow_wr
            assign bank_we    = we_i & (wptr[BANK_W-1:0] == BANK_W'(b));
            assign bank_wdata = w_data;
        end

        iob_2p_ram #(
            .DATA_W (MINW),
            .ADDR_W (ROW_W)
        ) u_ram (
            .clk    (clk),
            .w_en   (bank_we),
            .w_addr (w_row),
            .w_data (bank_wdata),
            .r_addr (r_row),
            .r_data (bank_rdata[b])
        );
    end

    // ---------------------------------------------------------------------
    // Read word assembly
    // ---------------------------------------------------------------------
    if (NB == 1) begin : g_rd_one
        assign rd_word = bank_rdata[0];
    end else if (RR > 1) begin : g_rd_wide
        for (genvar b = 0; b < NB; b++) begin : g_slice
            assign rd_word[b*MINW +: MINW] = bank_rdata[b];
        end
    end else begin : g_rd_narrow
        assign rd_word = bank_rdata[rptr[BANK_W-1:0]];
    end

    // ---------------------------------------------------------------------
    // Pointers, level, flags and read register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            r_data       <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
`ifdef IOB_SYNC_FIFO_ASYM_FWFT_EN
            pf_valid     <= 1'b0;
`endif
        end else begin
            level        <= lvl_next[ADDR_W:0];
            full         <= lvl_next > FULL_THR;
            almost_full  <= lvl_next >= AF_THR;
            almost_empty <= lvl_next <= AE_THR;

            if (we_i) begin
                wptr <= wptr + WR_P;
            end

            if (mem_rd) begin
                rptr   <= rptr + RR_P;
                r_data <= rd_word;
            end

`ifdef IOB_SYNC_FIFO_ASYM_FWFT_EN
            if (mem_rd) begin
                pf_valid <= 1'b1;
            end else if (pop) begin
                pf_valid <= 1'b0;
            end
            empty <= ~(mem_rd | (pf_valid & ~pop));
`else
            // A partial wide word (0 < level < RR) still reads as empty.
            empty <= lvl_next < RR_L;
`endif
        end
    end
endmodule

// File: tb/tb_iob_sync_fifo_asym.sv
`timescale 1ns/1ps
module tb_iob_sync_fifo_asym;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // narrow-to-wide: 8 -> 32
    logic [7:0]  n_wd;
    logic        n_we, n_re;
    logic [31:0] n_rd;
    logic        n_full, n_af, n_empty, n_ae;
    logic [4:0]  n_lvl;

    // wide-to-narrow: 32 -> 8
    logic [31:0] w_wd;
    logic        w_we, w_re;
    logic [7:0]  w_rd;
    logic        w_full, w_af, w_empty, w_ae;
    logic [4:0]  w_lvl;

    // symmetric: 8 -> 8
    logic [7:0]  s_wd;
    logic        s_we, s_re;
    logic [7:0]  s_rd;
    logic        s_full, s_af, s_empty, s_ae;
    logic [4:0]  s_lvl;

    iob_sync_fifo_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4),
                         .AFULL_LVL(12), .AEMPTY_LVL(4)) u_n2w (
        .clk(clk), .rst(rst), .w_data(n_wd), .write_en(n_we), .full(n_full),
        .almost_full(n_af), .r_data(n_rd), .read_en(n_re), .empty(n_empty),
        .almost_empty(n_ae), .level(n_lvl));

    iob_sync_fifo_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4),
                         .AFULL_LVL(12), .AEMPTY_LVL(4)) u_w2n (
        .clk(clk), .rst(rst), .w_data(w_wd), .write_en(w_we), .full(w_full),
        .almost_full(w_af), .r_data(w_rd), .read_en(w_re), .empty(w_empty),
        .almost_empty(w_ae), .level(w_lvl));

    iob_sync_fifo_asym #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(4),
                         .AFULL_LVL(12), .AEMPTY_LVL(4)) u_sym (
        .clk(clk), .rst(rst), .w_data(s_wd), .write_en(s_we), .full(s_full),
        .almost_full(s_af), .r_data(s_rd), .read_en(s_re), .empty(s_empty),
        .almost_empty(s_ae), .level(s_lvl));

    // Scoreboards: expected read words, pushed when a read is issued.
    logic [31:0] q_n [$];
    logic [7:0]  q_w [$];
    logic [7:0]  q_s [$];

    // Reference model for the symmetric instance.
    logic [7:0] s_model [$];
    int         s_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: an accepted read (read_en & ~empty at the edge) must present
    // the next scoreboard word on r_data after that edge.
    logic n_fire = 1'b0, w_fire = 1'b0, s_fire = 1'b0;
    always @(posedge clk) begin
        n_fire <= n_re & ~n_empty;
        w_fire <= w_re & ~w_empty;
        s_fire <= s_re & ~s_empty;
    end

    always @(negedge clk) begin
        if (n_fire) begin
            if (q_n.size() == 0) begin
                checks++; errors++;
                $display("FAIL n2w_rdata: got 0x%0h expected no read", n_rd);
            end else chk("n2w_rdata", n_rd, q_n.pop_front());
        end
        if (w_fire) begin
            if (q_w.size() == 0) begin
                checks++; errors++;
                $display("FAIL w2n_rdata: got 0x%0h expected no read", w_rd);
            end else chk("w2n_rdata", {24'h0, w_rd}, {24'h0, q_w.pop_front()});
        end
        if (s_fire) begin
            if (q_s.size() == 0) begin
                checks++; errors++;
                $display("FAIL sym_rdata: got 0x%0h expected no read", s_rd);
            end else chk("sym_rdata", {24'h0, s_rd}, {24'h0, q_s.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle on the symmetric FIFO, checked against the model.
    task automatic s_cycle(input logic we, input logic [7:0] wd, input logic re);
        bit acc_w, acc_r;
        acc_r = re && (s_cnt > 0);
        acc_w = we && (s_cnt < 16);
        s_we = we; s_wd = wd; s_re = re;
        if (acc_r) q_s.push_back(s_model.pop_front());
        if (acc_w) s_model.push_back(wd);
        s_cnt = s_cnt + int'(acc_w) - int'(acc_r);
        tick();
        s_we = 1'b0; s_re = 1'b0;
        chk("sym_level", {27'h0, s_lvl}, s_cnt);
        chk("sym_full",  {31'h0, s_full},  {31'h0, (s_cnt > 15)});
        chk("sym_empty", {31'h0, s_empty}, {31'h0, (s_cnt < 1)});
        chk("sym_afull", {31'h0, s_af},    {31'h0, (s_cnt >= 12)});
        chk("sym_aempty",{31'h0, s_ae},    {31'h0, (s_cnt <= 4)});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cnt;
        rst = 1'b1;
        n_wd = '0; n_we = 0; n_re = 0;
        w_wd = '0; w_we = 0; w_re = 0;
        s_wd = '0; s_we = 0; s_re = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_n_level",  {27'h0, n_lvl}, 0);
        chk("rst_n_empty",  {31'h0, n_empty}, 1);
        chk("rst_n_full",   {31'h0, n_full}, 0);
        chk("rst_n_aempty", {31'h0, n_ae}, 1);
        chk("rst_n_afull",  {31'h0, n_af}, 0);
        chk("rst_n_rdata",  n_rd, 0);
        chk("rst_w_rdata",  {24'h0, w_rd}, 0);
        chk("rst_s_empty",  {31'h0, s_empty}, 1);

        // narrow-to-wide, including a partial wide word
        n_we = 1; n_wd = 8'h11; tick();
        chk("n2w_empty_w1", {31'h0, n_empty}, 1);
        chk("n2w_level_w1", {27'h0, n_lvl}, 1);
        n_wd = 8'h22; tick(); n_we = 0;
        chk("n2w_level_w2", {27'h0, n_lvl}, 2);
        n_re = 1; tick(); n_re = 0;
        chk("n2w_partial_level", {27'h0, n_lvl}, 2);
        chk("n2w_partial_empty", {31'h0, n_empty}, 1);
        n_we = 1; n_wd = 8'h33; tick();
        chk("n2w_empty_w3", {31'h0, n_empty}, 1);
        n_wd = 8'h44; tick(); n_we = 0;
        chk("n2w_empty_w4", {31'h0, n_empty}, 0);
        chk("n2w_level_w4", {27'h0, n_lvl}, 4);
        q_n.push_back(32'h44332211);
        n_re = 1; tick(); n_re = 0;
        chk("n2w_level_rd", {27'h0, n_lvl}, 0);
        chk("n2w_empty_rd", {31'h0, n_empty}, 1);

        // wide-to-narrow
        w_we = 1; w_wd = 32'hDEADBEEF; tick(); w_we = 0;
        chk("w2n_level_w", {27'h0, w_lvl}, 4);
        chk("w2n_empty_w", {31'h0, w_empty}, 0);
        chk("w2n_aempty_w", {31'h0, w_ae}, 1);
        q_w.push_back(8'hEF); q_w.push_back(8'hBE);
        q_w.push_back(8'hAD); q_w.push_back(8'hDE);
        w_re = 1; repeat (4) tick(); w_re = 0;
        chk("w2n_empty_drain", {31'h0, w_empty}, 1);
        w_re = 1; tick(); w_re = 0;
        chk("w2n_hold_rdata", {24'h0, w_rd}, 32'hDE);
        chk("w2n_hold_level", {27'h0, w_lvl}, 0);

        // fill / overflow on wide-to-narrow
        for (int i = 0; i < 4; i++) begin
            w_we = 1;
            w_wd = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            tick();
            if (i == 2) begin
                chk("fill_level_12", {27'h0, w_lvl}, 12);
                chk("fill_full_12",  {31'h0, w_full}, 0);
                chk("fill_afull_12", {31'h0, w_af}, 1);
            end
        end
        w_we = 0;
        chk("fill_level_16", {27'h0, w_lvl}, 16);
        chk("fill_full_16",  {31'h0, w_full}, 1);
        w_we = 1; w_wd = 32'hFFFFFFFF; tick(); w_we = 0;
        chk("overflow_level", {27'h0, w_lvl}, 16);
        for (int b = 0; b < 16; b++) q_w.push_back(8'(b));
        w_re = 1; tick(); w_re = 0;
        chk("fill_level_15", {27'h0, w_lvl}, 15);
        chk("fill_full_15",  {31'h0, w_full}, 1);
        w_re = 1; repeat (15) tick(); w_re = 0;
        chk("fill_drain_empty", {31'h0, w_empty}, 1);
        chk("fill_drain_level", {27'h0, w_lvl}, 0);

        // symmetric: simultaneous read/write at level 5 and at full
        for (int i = 0; i < 5; i++) s_cycle(1'b1, 8'(8'h50 + i), 1'b0);
        s_cycle(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 11; i++) s_cycle(1'b1, 8'(8'h60 + i), 1'b0);
        s_cycle(1'b1, 8'hEE, 1'b1);
        for (int k = 0; k < 20 && s_cnt > 0; k++) s_cycle(1'b0, 8'h00, 1'b1);
        s_cycle(1'b0, 8'h00, 1'b1);

        // 100-word stream with threshold sweeps and pointer wraps
        wr_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            int  ph;
            bit  we, re;
            if (wr_cnt >= 100 && s_cnt == 0) break;
            ph = c % 32;
            we = (wr_cnt < 100) && (ph < 18);
            re = (ph >= 14) || (wr_cnt >= 100);
            if (we && s_cnt < 16) begin
                s_cycle(1'b1, 8'(wr_cnt + 1), re);
                wr_cnt++;
            end else begin
                s_cycle(we, 8'(wr_cnt + 1), re);
            end
        end

        // asynchronous reset mid-operation at level 9
        for (int i = 0; i < 9; i++) s_cycle(1'b1, 8'(8'hA0 + i), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", {27'h0, s_lvl}, 0);
        chk("arst_empty", {31'h0, s_empty}, 1);
        chk("arst_full",  {31'h0, s_full}, 0);
        chk("arst_aempty",{31'h0, s_ae}, 1);
        chk("arst_rdata", {24'h0, s_rd}, 0);
        #1 rst = 1'b0;
        s_model.delete();
        s_cnt = 0;
        @(negedge clk);
        s_cycle(1'b1, 8'h12, 1'b0);
        s_cycle(1'b1, 8'h34, 1'b0);
        s_cycle(1'b0, 8'h00, 1'b1);
        s_cycle(1'b0, 8'h00, 1'b1);

        tick();
        chk("n2w_sb_drained", q_n.size(), 0);
        chk("w2n_sb_drained", q_w.size(), 0);
        chk("sym_sb_drained", q_s.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
